// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
//   NUM_REQ : number of requesters sharing the resource
//   IDX_W   : width of an encoded requester index
//   state_t : arbiter FSM state encoding
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/decoder_2to4.sv
// Enabled 2-to-4 one-hot decoder.
//   i_en  : when 0 the output is all zero
//   i_in  : encoded index
//   o_out : one-hot decode of i_in, or zero
module decoder_2to4 (
  input  logic       i_en,
  input  logic [1:0] i_in,
  output logic [3:0] o_out
);
  always_comb begin
    o_out = 4'b0000;
    if (i_en) o_out = 4'b0001 << i_in;
  end
endmodule

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder.
//   i_req : request vector
//   i_ptr : highest-priority index; order is ptr, ptr+1, ... mod NUM_REQ
//   o_idx : first requesting index in that order (i_ptr when none)
//   o_any : at least one request is set
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  logic [IDX_W-1:0] w_cand;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    o_idx  = i_ptr;
    w_cand = i_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = i_ptr + IDX_W'(i);
      if (i_req[w_cand]) o_idx = w_cand;
    end
    o_any = |i_req;
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered grant and hold limit.
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   en        : allows new grants to be issued
//   req       : level-sensitive requests, held until served
//   done      : owner completion pulse
//   gnt       : one-hot grant bus, zero when idle
//   gnt_id    : encoded owner index
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse after a hold-limit revocation
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);
  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [IDX_W-1:0] w_pick_ptr;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_any;
  logic             w_own_req;
  logic             w_hold_hit;
  logic             w_release;
  logic             w_to;

  // On release the pointer moves past the current owner, and the
  // immediate re-pick must already use that new pointer.
  assign w_pick_ptr = (r_state == S_GRANT) ? IDX_W'(r_gnt_id + 1'b1) : r_ptr;

  rr_pick u_pick (
    .i_req (req),
    .i_ptr (w_pick_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  assign w_own_req  = req[r_gnt_id];
  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign w_release  = done | ~w_own_req | w_hold_hit;
  // Timeout only flags revocations the owner did not cause itself.
  assign w_to       = w_hold_hit & ~done & w_own_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_any) begin
            r_gnt_id    <= w_pick_idx;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_ptr      <= w_pick_ptr;
            r_timeout  <= w_to;
            r_hold_cnt <= '0;
            if (en && w_any) begin
              r_gnt_id <= w_pick_idx;
            end else begin
              r_gnt_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // gnt_valid is cleared by the async reset, so gnt drops with rst.
  decoder_2to4 u_dec (
    .i_en  (r_gnt_valid),
    .i_in  (r_gnt_id),
    .o_out (gnt)
  );

  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Monitor: after every edge, compare outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ((gnt !== e.gnt) || (gnt_valid !== e.v) || (timeout !== e.t) ||
          (e.v && (gnt_id !== e.id))) begin
        $display("FAIL %s: got gnt=%b id=%0d v=%b to=%b, need gnt=%b id=%0d v=%b to=%b",
                 e.nm, gnt, gnt_id, gnt_valid, timeout, e.gnt, e.id, e.v, e.t);
      end else begin
        n_pass++;
      end
    end
  end

  // Apply inputs for one edge and queue the outputs expected after it.
  task automatic step(input logic [3:0] r, input logic e, input logic d,
                      input logic [3:0] eg, input logic [1:0] eid,
                      input logic ev, input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    req  = r;
    en   = e;
    done = d;
    x.gnt = eg; x.id = eid; x.v = ev; x.t = et; x.nm = nm;
    sb.push_back(x);
    @(posedge clk);
  endtask

  task automatic direct(input string nm, input logic [3:0] eg, input logic ev,
                        input logic et);
    n_chk++;
    if ((gnt !== eg) || (gnt_valid !== ev) || (timeout !== et)) begin
      $display("FAIL %s: got gnt=%b v=%b to=%b, need gnt=%b v=%b to=%b",
               nm, gnt, gnt_valid, timeout, eg, ev, et);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    #12;
    direct("reset", 4'b0000, 1'b0, 1'b0);
    n_chk++;
    if (gnt_id !== 2'd0) $display("FAIL reset_id: got %0d, need 0", gnt_id);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;

    // Full rotation with done every cycle, wrapping 3 -> 0.
    step(4'b1111, 1, 0, 4'b0001, 0, 1, 0, "rot_first");
    step(4'b1111, 1, 1, 4'b0010, 1, 1, 0, "rot_1");
    step(4'b1111, 1, 1, 4'b0100, 2, 1, 0, "rot_2");
    step(4'b1111, 1, 1, 4'b1000, 3, 1, 0, "rot_3");
    step(4'b1111, 1, 1, 4'b0001, 0, 1, 0, "rot_wrap");
    step(4'b0000, 1, 0, 4'b0000, 0, 0, 0, "rot_idle");

    // Sole requester re-granted back-to-back (ptr now 1).
    step(4'b0100, 1, 0, 4'b0100, 2, 1, 0, "sole_g");
    for (int k = 0; k < 2; k++) begin
      step(4'b0100, 1, 0, 4'b0100, 2, 1, 0, "sole_hold");
      step(4'b0100, 1, 0, 4'b0100, 2, 1, 0, "sole_hold");
      step(4'b0100, 1, 1, 4'b0100, 2, 1, 0, "sole_regrant");
    end
    step(4'b0000, 1, 0, 4'b0000, 0, 0, 0, "sole_idle");

    // Hold limit of 4 cycles, then timeout and gapless hand-off (ptr now 3).
    step(4'b0010, 1, 0, 4'b0010, 1, 1, 0, "hold_c1");
    step(4'b1010, 1, 0, 4'b0010, 1, 1, 0, "hold_c2");
    step(4'b1010, 1, 0, 4'b0010, 1, 1, 0, "hold_c3");
    step(4'b1010, 1, 0, 4'b0010, 1, 1, 0, "hold_c4");
    step(4'b1010, 1, 0, 4'b1000, 3, 1, 1, "timeout_pulse");
    step(4'b0000, 1, 0, 4'b0000, 0, 0, 0, "timeout_clear");

    // Owner drops request; then done coincides with hold limit (ptr now 0).
    step(4'b0001, 1, 0, 4'b0001, 0, 1, 0, "drop_g0");
    step(4'b0110, 1, 0, 4'b0010, 1, 1, 0, "drop_to1");
    step(4'b0110, 1, 0, 4'b0010, 1, 1, 0, "both_c2");
    step(4'b0110, 1, 0, 4'b0010, 1, 1, 0, "both_c3");
    step(4'b0110, 1, 0, 4'b0010, 1, 1, 0, "both_c4");
    step(4'b0110, 1, 1, 4'b0100, 2, 1, 0, "both_no_to");
    step(4'b0000, 1, 0, 4'b0000, 0, 0, 0, "both_idle");

    // Enable gating (ptr now 3).
    step(4'b1000, 0, 0, 4'b0000, 0, 0, 0, "en0_a");
    step(4'b1000, 0, 0, 4'b0000, 0, 0, 0, "en0_b");
    step(4'b1000, 1, 0, 4'b1000, 3, 1, 0, "en1_grant");
    step(4'b1000, 0, 0, 4'b1000, 3, 1, 0, "en0_keep_a");
    step(4'b1000, 0, 0, 4'b1000, 3, 1, 0, "en0_keep_b");
    step(4'b1000, 0, 1, 4'b0000, 0, 0, 0, "en0_release");

    // Move ptr to 3 with a live grant, then reset asynchronously.
    step(4'b0100, 1, 0, 4'b0100, 2, 1, 0, "pre_rst_g2");
    step(4'b1100, 1, 1, 4'b1000, 3, 1, 0, "pre_rst_g3");
    #3;
    rst = 1'b1;
    #1;
    direct("async_rst", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    req = 4'b0000;
    done = 1'b0;
    rst = 1'b0;
    step(4'b1111, 1, 0, 4'b0001, 0, 1, 0, "post_rst_ptr0");
    step(4'b1111, 1, 1, 4'b0010, 1, 1, 0, "post_rst_next");
    step(4'b0000, 1, 0, 4'b0000, 0, 0, 0, "final_idle");

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, need 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
Round-robin arbiter that shares one resource among four requesters. Issues a single registered grant, holds it until the owner finishes, drops its request, or exceeds a hold limit, then rotates priority. The grant index drives the existing 2-to-4 decoder to produce the one-hot grant bus that selects the resource's owner.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; 0 disables the timeout.
CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  arbitration enable; when 0, no new grant is issued
req  input  4  request per requester, level-sensitive, held until served
done  input  1  owner signals completion (single-cycle pulse, meaningful only while gnt_valid=1)
gnt  output  4  one-hot grant, all zero when idle
gnt_id  output  2  encoded index of current owner
gnt_valid  output  1  a grant is active
timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Reset (async, immediate): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state S_IDLE. Reset mid-grant drops gnt combinationally with rst.
- ptr (2 bits) is the highest-priority index. Pick order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- S_IDLE: at an edge with en=1 and req!=0, latch the first requesting index in pick order into gnt_id. Set gnt_valid=1, clear hold_cnt, go to S_GRANT. Latency: req high before edge N gives gnt visible after edge N (one registered stage). With en=0 or req=0, stay idle.
- S_GRANT release conditions, evaluated at each edge:
  (a) done=1
  (b) req[gnt_id]=0
  (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
- Otherwise hold_cnt increments.
- On release: ptr <= gnt_id+1 (wraps 3->0). At the same edge, if en=1 and any req is set, pick immediately using the new ptr. This gives back-to-back grants with no dead cycle, gnt_valid stays 1, gnt_id updates, and hold_cnt clears. If no pick is made, go to S_IDLE with gnt_valid=0.
- The previous owner is last in the new pick order. It is re-granted only if it is the sole requester.
- timeout=1 for exactly the cycle after a release caused by (c) alone. If done=1 or req[gnt_id]=0 at the same edge, it is a normal release with no timeout pulse.
- en=0 during S_GRANT does not revoke the current grant. It only blocks new picks at release.
- Requests from non-owners during a grant are ignored until release.
- gnt = decoder_2to4(enable=gnt_valid, in=gnt_id). It is always one-hot or zero, and never has more than one bit set.
- hold_cnt saturates and never wraps. It is unused when MAX_HOLD=0.

Decomposition:
- Shared package arb_pkg holds: NUM_REQ=4, IDX_W=2, state encoding S_IDLE=1'b0 and S_GRANT=1'b1.
- One natural sub-module, rr_pick: combinational rotating priority encoder (req[3:0], ptr[1:0] -> idx[1:0], any).
- The existing decoder_2to4 is instantiated for the gnt output.

Test Plan:
- Reset then req=4'b1111, en=1 -> after first edge gnt=0001, gnt_id=0. Pulse done -> next edge gnt=0010, then 0100, then 1000, then 0001 (full rotation, wrap 3->0).
- Only req[2] held high, done pulsed every 3 cycles -> gnt stays 0100 back-to-back, gnt_valid never drops.
- MAX_HOLD=4, req[1] held, no done -> gnt=0010 for exactly 4 cycles, then timeout=1 for one cycle. With req[3] also high, gnt=1000 follows with no gap.
- Owner drops req[0] while req=4'b0110 -> next edge gnt=0010. Then done and hold-limit on the same edge -> no timeout pulse, gnt=0100.
- en=0 with req=4'b1000 -> gnt stays 0. Set en=1 -> gnt=1000 one edge later. Clear en mid-grant -> grant kept until done, then gnt=0.
- Assert rst mid-grant asynchronously -> gnt=0, gnt_valid=0 before the next clock. After release with req=4'b1111 -> gnt=0001 (ptr back to 0).
